// File: rtl/keypad_bcd_encoder_pkg.sv
// Shared types and constants for the keypad BCD encoder: FSM states, BCD digit type
// and the key-to-code helper used by the encoder.
package keypad_bcd_encoder_pkg;

   localparam int NUM_KEYS = 10;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [2:0] {
      IDLE,
      PRESS,
      HELD,
      RELEASE,
      FULL
   } state_t;

   // Highest set key index; a one-hot pattern therefore maps to its only set bit.
   function automatic bcd_digit_t highest_key(input logic [NUM_KEYS-1:0] k);
      bcd_digit_t code;
      code = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (k[i]) begin
            code = bcd_digit_t'(i);
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_bcd_encoder_sync_2ff.sv
// Two-flop synchroniser for the asynchronous key lines; both stages reset to zero.
module sync_2ff
   import keypad_bcd_encoder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Debounces a 10-line decimal keypad, encodes presses to BCD and packs them into
// DIGITS-wide frames handed off with a valid/ready handshake.
module keypad_bcd_encoder
   import keypad_bcd_encoder_pkg::*;
#(
   parameter int DIGITS          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PRIORITY_MODE   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_KEYS-1:0]          key,
   input  logic                         clear,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [4*DIGITS-1:0]          bcd_out,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         err
);

   localparam int             CW         = $clog2(DIGITS + 1);
   localparam logic [7:0]     CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  COUNT_FULL = CW'(DIGITS);

   logic [NUM_KEYS-1:0] ks;
   logic                key_multi;
   logic                key_legal;
   bcd_digit_t          key_code;

   state_t               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [NUM_KEYS-1:0]  pat_q, pat_d;
   bcd_digit_t           code_q, code_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   sync_2ff #(
      .WIDTH (NUM_KEYS)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (key),
      .q   (ks)
   );

   always_comb begin
      key_multi = (ks != '0) && !$onehot(ks);
      key_legal = (ks != '0) && ((PRIORITY_MODE != 0) || !key_multi);
      key_code  = highest_key(ks);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      code_d  = code_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      err_d   = 1'b0;

      // Clear outranks commit, handshake and error alike.
      if (clear) begin
         bcd_d   = '0;
         count_d = '0;
         state_d = HELD;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_legal) begin
                  pat_d   = ks;
                  code_d  = key_code;
                  cnt_d   = 8'd1;
                  state_d = PRESS;
               end else if (key_multi) begin
                  err_d   = 1'b1;
                  state_d = HELD;
               end
            end
            PRESS: begin
               if (ks != pat_q) begin
                  state_d = IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  bcd_d      = bcd_q << 4;
                  bcd_d[3:0] = code_q;
                  count_d    = count_q + CW'(1);
                  state_d    = (count_d == COUNT_FULL) ? FULL : HELD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            HELD: begin
               if (ks == '0) begin
                  cnt_d   = 8'd1;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (ks != '0) begin
                  state_d = HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            FULL: begin
               // The last key may still be down, so re-arm through HELD.
               if (out_ready) begin
                  bcd_d   = '0;
                  count_d = '0;
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      valid_d = (state_d == FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pat_q   <= '0;
         code_q  <= '0;
         bcd_q   <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         code_q  <= code_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign out_valid   = valid_q;
   assign bcd_out     = bcd_q;
   assign digit_count = count_q;
   assign err         = err_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench: stimulus pushes expected digit/err/frame events, a negedge monitor
// pops and compares them as the DUTs (priority mode 0 and 1) produce them.
module tb_keypad_bcd_encoder;

   localparam int EV_DIGIT = 0;
   localparam int EV_ERR   = 1;
   localparam int EV_FRAME = 2;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        out_ready = 1'b0;
   logic [9:0]  key0 = '0;
   logic [9:0]  key1 = '0;
   logic        ov0, ov1, err0, err1;
   logic [15:0] bcd0, bcd1;
   logic [2:0]  dc0, dc1;

   ev_t exp0_q[$];
   ev_t exp1_q[$];
   int  checks = 0;
   int  failures = 0;
   int  prev0 = 0;
   int  prev1 = 0;

   always #5 clk = ~clk;

   keypad_bcd_encoder #(.DIGITS(4), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(0)) dut0 (
      .clk (clk), .rst (rst), .key (key0), .clear (clear), .out_ready (out_ready),
      .out_valid (ov0), .bcd_out (bcd0), .digit_count (dc0), .err (err0)
   );

   keypad_bcd_encoder #(.DIGITS(4), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(1)) dut1 (
      .clk (clk), .rst (rst), .key (key1), .clear (clear), .out_ready (out_ready),
      .out_valid (ov1), .bcd_out (bcd1), .digit_count (dc1), .err (err1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end else begin
         $display("check %s = 0x%0h ok", name, got);
      end
   endtask

   task automatic exp_ev(input int which, input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      if (which == 0) exp0_q.push_back(e);
      else            exp1_q.push_back(e);
   endtask

   task automatic observe(input int which, input int kind, input int val);
      ev_t e;
      bit  have;
      have = (which == 0) ? (exp0_q.size() > 0) : (exp1_q.size() > 0);
      checks++;
      if (!have) begin
         failures++;
         $display("FAIL dut%0d unexpected event: got kind=%0d val=0x%0h expected none", which, kind, val);
      end else begin
         if (which == 0) e = exp0_q.pop_front();
         else            e = exp1_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            failures++;
            $display("FAIL dut%0d event: got kind=%0d val=0x%0h expected kind=%0d val=0x%0h",
                     which, kind, val, e.kind, e.val);
         end else begin
            $display("dut%0d event kind=%0d val=0x%0h ok", which, kind, val);
         end
      end
   endtask

   // Monitor: a digit event is a +1 step of digit_count, tagged {count, low nibble}.
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(dc0) == prev0 + 1) observe(0, EV_DIGIT, int'(dc0) * 16 + int'(bcd0[3:0]));
         if (err0)                   observe(0, EV_ERR, 0);
         if (ov0 && out_ready)       observe(0, EV_FRAME, int'(bcd0));
         if (int'(dc1) == prev1 + 1) observe(1, EV_DIGIT, int'(dc1) * 16 + int'(bcd1[3:0]));
         if (err1)                   observe(1, EV_ERR, 0);
         if (ov1 && out_ready)       observe(1, EV_FRAME, int'(bcd1));
      end
      prev0 = int'(dc0);
      prev1 = int'(dc1);
   end

   task automatic press0(input logic [9:0] k);
      @(posedge clk); #1 key0 = k;
      repeat (10) @(posedge clk);
      #1 key0 = '0;
      repeat (10) @(posedge clk);
   endtask

   task automatic digit0(input logic [9:0] k, input int code, input int count);
      exp_ev(0, EV_DIGIT, count * 16 + code);
      press0(k);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic handshake();
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset bcd_out", 32'(bcd0), 32'h0);
      check("reset digit_count", 32'(dc0), 32'h0);
      check("reset out_valid", 32'(ov0), 32'h0);
      check("reset err", 32'(err0), 32'h0);
      @(negedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      // Four-digit frame and handshake
      digit0(10'h002, 1, 1);
      digit0(10'h004, 2, 2);
      digit0(10'h008, 3, 3);
      digit0(10'h010, 4, 4);
      #1;
      check("frame out_valid", 32'(ov0), 32'h1);
      check("frame bcd_out", 32'(bcd0), 32'h1234);
      exp_ev(0, EV_FRAME, 32'h1234);
      handshake();
      check("after xfer bcd_out", 32'(bcd0), 32'h0);
      check("after xfer digit_count", 32'(dc0), 32'h0);
      check("after xfer out_valid", 32'(ov0), 32'h0);
      repeat (8) @(posedge clk);

      // Bouncing key 5: 3 high, 1 low, then steady
      exp_ev(0, EV_DIGIT, 1 * 16 + 5);
      @(posedge clk); #1 key0 = 10'h020;
      repeat (3) @(posedge clk);
      #1 key0 = '0;
      @(posedge clk); #1 key0 = 10'h020;
      repeat (13) @(posedge clk);
      #1 key0 = '0;
      repeat (10) @(posedge clk);
      #1;
      check("bounce digit_count", 32'(dc0), 32'h1);
      check("bounce bcd_out", 32'(bcd0), 32'h0005);

      // Multi-hot 0 and 3: rejected in mode 0, digit 3 in mode 1
      exp_ev(0, EV_ERR, 0);
      exp_ev(1, EV_DIGIT, 1 * 16 + 3);
      @(posedge clk); #1 key0 = 10'b0000001001; key1 = 10'b0000001001;
      repeat (10) @(posedge clk);
      #1 key0 = '0; key1 = '0;
      repeat (10) @(posedge clk);
      #1;
      check("multihot mode0 digit_count", 32'(dc0), 32'h1);
      check("multihot mode1 digit_count", 32'(dc1), 32'h1);
      check("multihot mode1 bcd_out", 32'(bcd1), 32'h0003);

      pulse_clear();
      check("clear digit_count", 32'(dc0), 32'h0);

      // Full frame is frozen while key 7 is pressed
      digit0(10'h200, 9, 1);
      digit0(10'h100, 8, 2);
      digit0(10'h080, 7, 3);
      digit0(10'h040, 6, 4);
      @(posedge clk); #1 key0 = 10'h080;
      repeat (20) @(posedge clk);
      #1;
      check("full held bcd_out", 32'(bcd0), 32'h9876);
      check("full held digit_count", 32'(dc0), 32'h4);
      check("full held out_valid", 32'(ov0), 32'h1);
      exp_ev(0, EV_FRAME, 32'h9876);
      handshake();
      repeat (20) @(posedge clk);
      #1;
      check("held after xfer digit_count", 32'(dc0), 32'h0);
      key0 = '0;
      repeat (10) @(posedge clk);
      digit0(10'h080, 7, 1);
      #1;
      check("repress digit_count", 32'(dc0), 32'h1);

      // Clear coincident with the third commit
      pulse_clear();
      digit0(10'h002, 1, 1);
      digit0(10'h004, 2, 2);
      @(posedge clk); #1 key0 = 10'h008;
      repeat (5) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      check("clear at commit digit_count", 32'(dc0), 32'h0);
      check("clear at commit bcd_out", 32'(bcd0), 32'h0);
      repeat (4) @(posedge clk);
      #1 key0 = '0;
      repeat (10) @(posedge clk);
      digit0(10'h010, 4, 1);
      #1;
      check("after clear digit_count", 32'(dc0), 32'h1);
      check("after clear bcd_out", 32'(bcd0), 32'h0004);

      // Asynchronous reset mid-press, then a clean press with 6-edge latency
      @(posedge clk); #1 key0 = 10'h004;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst digit_count", 32'(dc0), 32'h0);
      check("async rst bcd_out", 32'(bcd0), 32'h0);
      key0 = '0;
      repeat (2) @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      exp_ev(0, EV_DIGIT, 1 * 16 + 6);
      @(posedge clk); #1 key0 = 10'h040;
      repeat (5) @(posedge clk);
      #1;
      check("latency edge5 digit_count", 32'(dc0), 32'h0);
      @(posedge clk); #1;
      check("latency edge6 digit_count", 32'(dc0), 32'h1);
      check("latency edge6 bcd_out", 32'(bcd0), 32'h0006);
      key0 = '0;
      repeat (10) @(posedge clk);

      #1;
      check("dut0 pending events", 32'(exp0_q.size()), 32'h0);
      check("dut1 pending events", 32'(exp1_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_bcd_encoder.md
KEYPAD_BCD_ENCODER -- requirements
Module: keypad_bcd_encoder

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in one output frame; legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required for press and for release; legal range 2..255.
REQ-003 Parameter PRIORITY_MODE, default 0: 0 rejects multi-hot key patterns; 1 makes the highest-index set bit win.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 key  input  10  decimal key lines; key[n] high means digit n is pressed; asynchronous to clk.
REQ-007 clear  input  1  synchronous abort: discards the partial frame and any pending output.
REQ-008 out_ready  input  1  consumer accepts the frame.
REQ-009 out_valid  output  1  a full frame is presented.
REQ-010 bcd_out  output  4*DIGITS  packed BCD frame; the most recently entered digit is in bits [3:0].
REQ-011 digit_count  output  clog2(DIGITS+1)  number of digits entered into the current frame.
REQ-012 err  output  1  one-cycle pulse when a press is rejected.

Function
REQ-013 key shall pass through a 2-flop synchroniser; all further references to key mean the synchronised value ks.
REQ-014 Encoding shall follow this rule: a one-hot ks maps bit n to BCD n (0..9); in PRIORITY_MODE=1, a multi-hot ks maps to its highest set index; ks=0 means no key.
REQ-015 The FSM shall have exactly the states IDLE, PRESS, HELD, RELEASE and FULL.
REQ-016 IDLE: ks=0 stays in IDLE; a legal nonzero ks captures the pattern and code, sets cnt=1 and goes to PRESS.
REQ-017 IDLE with multi-hot ks and PRIORITY_MODE=0: err pulses for one cycle, nothing is captured, and the FSM goes to HELD.
REQ-018 PRESS: if ks equals the captured pattern, cnt increments; if ks differs in any way, the FSM returns to IDLE and no digit is committed.
REQ-019 PRESS commit: on the edge where cnt would reach DEBOUNCE_CYCLES, bcd_out shifts left by 4 with the new code in [3:0], digit_count increments, and the FSM goes to HELD.
REQ-020 Press latency: the digit shall be visible 2+DEBOUNCE_CYCLES edges after the key becomes stable at the pin.
REQ-021 HELD: ks=0 sets cnt=1 and goes to RELEASE; otherwise the FSM stays in HELD, and key changes while held are ignored.
REQ-022 RELEASE: ks=0 increments cnt, and reaching DEBOUNCE_CYCLES goes to IDLE; any nonzero ks returns to HELD.
REQ-023 Frame completion: a commit that makes digit_count==DIGITS shall go to FULL instead of HELD, with out_valid high on the next cycle.
REQ-024 FULL: out_valid=1 and bcd_out/digit_count are frozen; key activity is ignored and err never pulses.
REQ-025 FULL with out_ready=1: the handshake completes, bcd_out=0, digit_count=0, out_valid=0, and the FSM goes to HELD (the last key must be released first).
REQ-026 out_valid shall be high only in FULL; out_valid and bcd_out are registered outputs.
REQ-027 clear=1, from any state: bcd_out=0, digit_count=0, out_valid=0 and err=0, and the FSM goes to HELD.
REQ-028 Simultaneous events: clear takes priority over commit, the handshake and err; clear together with out_ready counts as a discard, not a transfer.
REQ-029 Codes shall always be in 0..9; no non-BCD nibble shall ever appear on bcd_out.

Reset
REQ-030 rst=1 shall asynchronously force the FSM to IDLE, cnt=0, the synchroniser flops to 0, bcd_out=0, digit_count=0, out_valid=0 and err=0.
REQ-031 Reset asserted mid-press or mid-frame shall drop the partial frame, with no output transfer after release.
REQ-032 Deassertion is synchronised externally; the block shall resume in IDLE on the first edge after rst falls.

Structure
REQ-033 The shared package shall hold the FSM state enum, the BCD digit typedef (4 bits) and the constant NUM_KEYS=10.
REQ-034 The synchroniser shall be the sub-module sync_2ff (parameter WIDTH, reset to 0); the encoder and FSM stay in keypad_bcd_encoder.

Verification (DIGITS=4, DEBOUNCE_CYCLES=4, PRIORITY_MODE=0 unless stated)
REQ-035 Enter keys 1,2,3,4, each held for 10 cycles with 10 idle cycles between -> out_valid=1 with bcd_out=16'h1234; out_ready=1 -> bcd_out=0, digit_count=0.
REQ-036 key[5] bounces 3 cycles high, 1 low, 3 high, then steady -> exactly one digit 5 is committed.
REQ-037 key=10'b0000001001 -> err pulses for 1 cycle and digit_count is unchanged; repeat with PRIORITY_MODE=1 -> digit 3 is committed.
REQ-038 Frame full with out_ready=0 and key[7] pressed -> bcd_out is held and no 5th digit appears; out_ready with key[7] still held -> no commit until release and a new press.
REQ-039 clear asserted in the same cycle as a commit after 2 digits -> bcd_out=0, digit_count=0, and the next press yields digit_count=1.
REQ-040 rst pulsed asynchronously (between clock edges) mid-press -> outputs are 0 immediately, and a clean press afterwards yields normal latency of 6 edges.
